// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 raster geometry shared by the timing generator and its axis counters.
package vga_timing_pkg;

  localparam int unsigned HActive  = 640;
  localparam int unsigned HFp      = 16;
  localparam int unsigned HSync    = 96;
  localparam int unsigned HBp      = 48;
  localparam int unsigned HTotal   = HActive + HFp + HSync + HBp;

  localparam int unsigned VActive  = 480;
  localparam int unsigned VFp      = 10;
  localparam int unsigned VSync    = 2;
  localparam int unsigned VBp      = 33;
  localparam int unsigned VTotal   = VActive + VFp + VSync + VBp;

  localparam int unsigned CntWidth = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap chaining, plus sync/active decode of the next count.
module vga_axis_counter #(
  parameter int unsigned Active = 640,
  parameter int unsigned Fp     = 16,
  parameter int unsigned Sync   = 96,
  parameter int unsigned Bp     = 48,
  parameter int unsigned Width  = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             step_i,
  output logic [Width-1:0] cnt_o,
  output logic             wrap_o,
  output logic             sync_n_d_o,
  output logic             active_d_o
);

  localparam int unsigned Total     = Active + Fp + Sync + Bp;
  localparam int unsigned SyncFirst = Active + Fp;
  localparam int unsigned SyncLast  = Active + Fp + Sync - 1;

  logic [Width-1:0] cnt_d, cnt_q;
  logic             last;

  assign last   = (cnt_q == Width'(Total - 1));
  assign wrap_o = step_i & last;

  always_comb begin
    cnt_d = cnt_q;
    if (step_i) begin
      cnt_d = last ? '0 : cnt_q + Width'(1);
    end
  end

  // Decoded from cnt_d so the caller can register them alongside the counter itself.
  always_comb begin
    sync_n_d_o = 1'b1;
    active_d_o = 1'b0;
    if (cnt_d >= Width'(SyncFirst) && cnt_d <= Width'(SyncLast)) begin
      sync_n_d_o = 1'b0;
    end
    if (cnt_d < Width'(Active)) begin
      active_d_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= Width'(Total - 1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with fully registered, skew-free outputs.
// Define VGA_FRAME_CNT_EN to add a 16-bit frame_cnt output counting frame_start pulses.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActive,
  parameter int unsigned H_FP     = HFp,
  parameter int unsigned H_SYNC   = HSync,
  parameter int unsigned H_BP     = HBp,
  parameter int unsigned V_ACTIVE = VActive,
  parameter int unsigned V_FP     = VFp,
  parameter int unsigned V_SYNC   = VSync,
  parameter int unsigned V_BP     = VBp
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic       line_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  logic       h_wrap, v_wrap;
  logic       h_sync_n_d, v_sync_n_d, h_active_d, v_active_d;
  logic [9:0] hc, vc;

  vga_axis_counter #(
    .Active(H_ACTIVE),
    .Fp    (H_FP),
    .Sync  (H_SYNC),
    .Bp    (H_BP),
    .Width (CntWidth)
  ) u_h_axis (
    .clk_i     (vga_clk),
    .reset_i   (reset),
    .step_i    (1'b1),
    .cnt_o     (hc),
    .wrap_o    (h_wrap),
    .sync_n_d_o(h_sync_n_d),
    .active_d_o(h_active_d)
  );

  vga_axis_counter #(
    .Active(V_ACTIVE),
    .Fp    (V_FP),
    .Sync  (V_SYNC),
    .Bp    (V_BP),
    .Width (CntWidth)
  ) u_v_axis (
    .clk_i     (vga_clk),
    .reset_i   (reset),
    .step_i    (h_wrap),
    .cnt_o     (vc),
    .wrap_o    (v_wrap),
    .sync_n_d_o(v_sync_n_d),
    .active_d_o(v_active_d)
  );

  logic hs_q, vs_q, blank_q, frame_start_q, line_start_q;

  // The horizontal counter steps every cycle, so its wrap means the next pixel has DrawX = 0.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      hs_q          <= h_sync_n_d;
      vs_q          <= v_sync_n_d;
      blank_q       <= h_active_d & v_active_d;
      frame_start_q <= v_wrap;
      line_start_q  <= h_wrap;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign DrawX       = hc;
  assign DrawY       = vc;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 raster for reset/line checks, a 16x11 raster for whole frames.
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_d, hs_d, vs_d, blank_d, fs_d, ls_d;
  logic [9:0] x_d, y_d;
  logic       rst_s, hs_s, vs_s, blank_s, fs_s, ls_s;
  logic [9:0] x_s, y_s;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fcnt_d, fcnt_s;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen dut_d (
    .vga_clk    (clk),
    .reset      (rst_d),
    .hs         (hs_d),
    .vs         (vs_d),
    .blank      (blank_d),
    .DrawX      (x_d),
    .DrawY      (y_d),
    .frame_start(fs_d),
    .line_start (ls_d)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt  (fcnt_d)
`endif
  );

  // 8+2+3+3 = 16 pixels per line, 6+1+2+2 = 11 lines per frame.
  vga_timing_gen #(
    .H_ACTIVE(8),
    .H_FP    (2),
    .H_SYNC  (3),
    .H_BP    (3),
    .V_ACTIVE(6),
    .V_FP    (1),
    .V_SYNC  (2),
    .V_BP    (2)
  ) dut_s (
    .vga_clk    (clk),
    .reset      (rst_s),
    .hs         (hs_s),
    .vs         (vs_s),
    .blank      (blank_s),
    .DrawX      (x_s),
    .DrawY      (y_s),
    .frame_start(fs_s),
    .line_start (ls_s)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt  (fcnt_s)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_cnt, hs_first, blank_fall, ls_cnt, err, n;
    int vs_cnt, vs_first_x, vs_first_y, fs_cnt;
    logic prev_blank;

    rst_d = 1'b1;
    rst_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_x", 32'(x_d), 799);
      check_eq("rst_y", 32'(y_d), 524);
    end
    check_eq("rst_hs", 32'(hs_d), 1);
    check_eq("rst_vs", 32'(vs_d), 1);
    check_eq("rst_blank", 32'(blank_d), 0);
    check_eq("rst_fs", 32'(fs_d), 0);
    check_eq("rst_ls", 32'(ls_d), 0);

    rst_d = 1'b0;
    step();
    check_eq("first_x", 32'(x_d), 0);
    check_eq("first_y", 32'(y_d), 0);
    check_eq("first_blank", 32'(blank_d), 1);
    check_eq("first_fs", 32'(fs_d), 1);
    check_eq("first_ls", 32'(ls_d), 1);
    check_eq("first_hs", 32'(hs_d), 1);

    // One full line 0, sampled pixel by pixel.
    hs_cnt = 0; hs_first = -1; blank_fall = -1; ls_cnt = 0; err = 0; prev_blank = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (32'(x_d) != i || y_d != 10'd0) err++;
      if (!hs_d) begin
        if (hs_cnt == 0) hs_first = 32'(x_d);
        hs_cnt++;
      end
      if (prev_blank && !blank_d) blank_fall = 32'(x_d);
      prev_blank = blank_d;
      if (ls_d) ls_cnt++;
      if (fs_d && i != 0) err++;
      step();
    end
    check_eq("line_coords", 32'(err), 0);
    check_eq("hs_low_len", 32'(hs_cnt), 96);
    check_eq("hs_low_start", 32'(hs_first), 656);
    check_eq("blank_fall_x", 32'(blank_fall), 640);
    check_eq("ls_per_line", 32'(ls_cnt), 1);
    check_eq("line1_ls", 32'(ls_d), 1);
    check_eq("line1_x", 32'(x_d), 0);
    check_eq("line1_y", 32'(y_d), 1);
    check_eq("line1_blank", 32'(blank_d), 1);

    // Mid-frame reset on the default raster.
    repeat (300) step();
    check_eq("mid_x", 32'(x_d), 300);
    rst_d = 1'b1;
    step();
    check_eq("mrst_x", 32'(x_d), 799);
    check_eq("mrst_y", 32'(y_d), 524);
    check_eq("mrst_hs", 32'(hs_d), 1);
    check_eq("mrst_vs", 32'(vs_d), 1);
    check_eq("mrst_blank", 32'(blank_d), 0);
    rst_d = 1'b0;
    step();
    check_eq("mrel_x", 32'(x_d), 0);
    check_eq("mrel_y", 32'(y_d), 0);
    check_eq("mrel_fs", 32'(fs_d), 1);

    // Small raster: whole frames.
    step();
    check_eq("s_rst_x", 32'(x_s), 15);
    check_eq("s_rst_y", 32'(y_s), 10);
    rst_s = 1'b0;
    step();
    check_eq("s_first_fs", 32'(fs_s), 1);
`ifdef VGA_FRAME_CNT_EN
    check_eq("fcnt_first", 32'(fcnt_s), 1);
`endif

    err = 0; vs_cnt = 0; vs_first_x = -1; vs_first_y = -1; fs_cnt = 0;
    for (int i = 0; i < 176; i++) begin
      int ex, ey;
      ex = i % 16;
      ey = i / 16;
      if (32'(x_s) != ex || 32'(y_s) != ey) err++;
      if (hs_s != !(ex >= 10 && ex <= 12)) err++;
      if (vs_s != !(ey >= 7 && ey <= 8)) err++;
      if (blank_s != (ex < 8 && ey < 6)) err++;
      if (ls_s != (ex == 0)) err++;
      if (fs_s != (i == 0)) err++;
      if (!vs_s) begin
        if (vs_cnt == 0) begin
          vs_first_x = 32'(x_s);
          vs_first_y = 32'(y_s);
        end
        vs_cnt++;
      end
      if (i == 175) begin
        check_eq("s_last_x", 32'(x_s), 15);
        check_eq("s_last_y", 32'(y_s), 10);
      end
      if (fs_s) fs_cnt++;
      step();
    end
    check_eq("s_model", 32'(err), 0);
    check_eq("s_vs_len", 32'(vs_cnt), 32);
    check_eq("s_vs_x", 32'(vs_first_x), 0);
    check_eq("s_vs_y", 32'(vs_first_y), 7);
    check_eq("s_fs_count", 32'(fs_cnt), 1);
    check_eq("s_wrap_x", 32'(x_s), 0);
    check_eq("s_wrap_y", 32'(y_s), 0);
    check_eq("s_wrap_fs", 32'(fs_s), 1);

    n = 0;
    do begin
      step();
      n++;
    end while (!fs_s && n < 400);
    check_eq("s_fs_period", 32'(n), 176);

`ifdef VGA_FRAME_CNT_EN
    step();
    force dut_s.frame_cnt_q = 16'hFFFF;
    step();
    release dut_s.frame_cnt_q;
    n = 0;
    do begin
      step();
      n++;
    end while (!fs_s && n < 400);
    check_eq("fcnt_wrap", 32'(fcnt_s), 0);
`endif

    repeat (90) step();
    check_eq("s_mid_x", 32'(x_s), 10);
    check_eq("s_mid_y", 32'(y_s), 5);
    rst_s = 1'b1;
    step();
    check_eq("s_mrst_x", 32'(x_s), 15);
    check_eq("s_mrst_y", 32'(y_s), 10);
    check_eq("s_mrst_hs", 32'(hs_s), 1);
    check_eq("s_mrst_blank", 32'(blank_s), 0);
    rst_s = 1'b0;
    step();
    check_eq("s_mrel_x", 32'(x_s), 0);
    check_eq("s_mrel_y", 32'(y_s), 0);
    check_eq("s_mrel_fs", 32'(fs_s), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
